// File: rtl/proc_mem_responder_if.sv
// Request/response message types and the handshake bundle that connects a
// requester (master) to proc_mem_responder (slave).
package proc_mem_responder_pkg;

  // Request: msg_type 0 = read, 1 = write, anything else behaves as a read.
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface proc_mem_responder_if;
  import proc_mem_responder_pkg::*;

  mem_req_4B_t  memreq_msg;
  logic         memreq_val;
  logic         memreq_rdy;
  mem_resp_4B_t memresp_msg;
  logic         memresp_val;
  logic         memresp_rdy;

  modport master (
    output memreq_msg, memreq_val, memresp_rdy,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  modport slave (
    input  memreq_msg, memreq_val, memresp_rdy,
    output memreq_rdy, memresp_msg, memresp_val
  );

endinterface

// File: rtl/proc_mem_responder.sv
// Single-port word memory answering val/rdy requests with a fixed extra
// latency of LATENCY cycles. Optional byte/halfword access is enabled by
// defining PROC_MEM_RESPONDER_SUBWORD_EN; otherwise every access is a full
// aligned word and len is only echoed back.
module proc_mem_responder #(
  parameter int NWORDS  = 256,
  parameter int LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  proc_mem_responder_if.slave  mem
);
  import proc_mem_responder_pkg::*;

  localparam int         AW  = $clog2(NWORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_4B_t req;
  logic        req_hs;
  logic        resp_hs;
  logic [AW-1:0] idx;
  logic        wr_en;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Storage is deliberately left out of reset so contents survive it.
  logic [31:0] mem_q [NWORDS];
  logic [31:0] rd_data_q;

  logic [2:0]  type_q;
  logic [7:0]  opaque_q;
  logic [1:0]  len_q;
  logic        is_read_q;
  logic [31:0] resp_data;

  assign req     = mem.memreq_msg;
  assign idx     = req.addr[AW+1:2];
  assign wr_en   = (req.msg_type == 3'd1);

  // Handshake outputs depend only on state and memresp_rdy, so the
  // request-ready path cannot loop back through the next-state logic.
  assign mem.memreq_rdy  = (state_q == IDLE) || ((state_q == RESP) && mem.memresp_rdy);
  assign mem.memresp_val = (state_q == RESP);
  assign req_hs  = mem.memreq_val && mem.memreq_rdy;
  assign resp_hs = mem.memresp_val && mem.memresp_rdy;

  // State and wait-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a new request accepted in RESP restarts the pipeline with no bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req_hs) begin
      state_d = (LAT == 4'd0) ? RESP : WAIT;
      cnt_d   = LAT;
    end
  end

`ifdef PROC_MEM_RESPONDER_SUBWORD_EN
  logic [1:0] off_q;

  // Byte lanes: steer low write data onto the addressed byte/halfword.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (req.len)
        2'd1: begin
          be[gi]             = (req.addr[1:0] == 2'(gi));
          wdata[8*gi +: 8]   = req.data[7:0];
        end
        2'd2: begin
          be[gi]             = (req.addr[1] == 1'(gi / 2));
          wdata[8*gi +: 8]   = req.data[8*(gi % 2) +: 8];
        end
        default: begin
          be[gi]             = 1'b1;
          wdata[8*gi +: 8]   = req.data[8*gi +: 8];
        end
      endcase
    end
  end

  // Zero-extend the selected byte/halfword of the registered word.
  always_comb begin
    case (len_q)
      2'd1:    resp_data = {24'd0, rd_data_q[8*off_q +: 8]};
      2'd2:    resp_data = {16'd0, rd_data_q[16*off_q[1] +: 16]};
      default: resp_data = rd_data_q;
    endcase
    if (!is_read_q) resp_data = 32'd0;
  end

  // Byte offset of the accepted request, needed to extract subword reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) off_q <= 2'd0;
    else if (req_hs) off_q <= req.addr[1:0];
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^req.addr[31:AW+2];
`else
  assign be    = 4'hF;
  assign wdata = req.data;

  // Full-word access only; writes answer with zero data.
  always_comb begin
    resp_data = is_read_q ? rd_data_q : 32'd0;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req.addr[31:AW+2], req.addr[1:0]};
`endif

  // Memory port: read-before-write at the request handshake edge.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      rd_data_q <= mem_q[idx];
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response header fields captured with each accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q    <= 3'd0;
      opaque_q  <= 8'd0;
      len_q     <= 2'd0;
      is_read_q <= 1'b0;
    end else if (req_hs) begin
      type_q    <= req.msg_type;
      opaque_q  <= req.opaque;
      len_q     <= req.len;
      is_read_q <= !wr_en;
    end
  end

  assign mem.memresp_msg = '{msg_type: type_q, opaque: opaque_q, test: 2'b00,
                             len: len_q, data: resp_data};

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed bench: one LATENCY=0 instance and one LATENCY=3 instance sharing
// clock and reset; each test task drives stimulus and checks inline.
module tb_proc_mem_responder;
  import proc_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  proc_mem_responder_if bus0();
  proc_mem_responder_if bus3();

  proc_mem_responder #(.NWORDS(256), .LATENCY(0)) dut0 (.clk(clk), .reset(rst), .mem(bus0));
  proc_mem_responder #(.NWORDS(256), .LATENCY(3)) dut3 (.clk(clk), .reset(rst), .mem(bus3));

`ifdef PROC_MEM_RESPONDER_SUBWORD_EN
  localparam logic [31:0] EXP_WORD20 = 32'h1234AB78;
  localparam logic [31:0] EXP_BYTE23 = 32'h00000012;
`else
  localparam logic [31:0] EXP_WORD20 = 32'h000000AB;
  localparam logic [31:0] EXP_BYTE23 = 32'h000000AB;
`endif

  // One transaction on the LATENCY=0 instance; lat = cycles from acceptance
  // to first memresp_val, 999 if a bound expired.
  task automatic xact0(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] opq, input logic [1:0] len,
                       output mem_resp_4B_t resp, output int lat);
    int n;
    @(negedge clk);
    bus0.memreq_msg  = '{msg_type: typ, opaque: opq, addr: addr, len: len, data: data};
    bus0.memreq_val  = 1'b1;
    bus0.memresp_rdy = 1'b1;
    n = 0;
    while (!bus0.memreq_rdy && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus0.memreq_val = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus0.memresp_val && lat < 20) begin @(negedge clk); lat++; end
    resp = bus0.memresp_msg;
    if (n >= 20 || !bus0.memresp_val) lat = 999;
    @(posedge clk); #1;
  endtask

  task automatic xact3(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] opq, input logic [1:0] len,
                       output mem_resp_4B_t resp, output int lat);
    int n;
    @(negedge clk);
    bus3.memreq_msg  = '{msg_type: typ, opaque: opq, addr: addr, len: len, data: data};
    bus3.memreq_val  = 1'b1;
    bus3.memresp_rdy = 1'b1;
    n = 0;
    while (!bus3.memreq_rdy && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus3.memreq_val = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus3.memresp_val && lat < 20) begin @(negedge clk); lat++; end
    resp = bus3.memresp_msg;
    if (n >= 20 || !bus3.memresp_val) lat = 999;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.memreq_val = 1'b0; bus0.memresp_rdy = 1'b0; bus0.memreq_msg = '0;
    bus3.memreq_val = 1'b0; bus3.memresp_rdy = 1'b0; bus3.memreq_msg = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus0.memreq_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy0: got %b expected 1", bus0.memreq_rdy); end
    checks++; if (bus0.memresp_val !== 1'b0) begin failures++; $display("FAIL reset_val0: got %b expected 0", bus0.memresp_val); end
    checks++; if (bus0.memresp_msg !== '0) begin failures++; $display("FAIL reset_msg0: got %h expected 0", bus0.memresp_msg); end
    checks++; if (bus3.memreq_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy3: got %b expected 1", bus3.memreq_rdy); end
    checks++; if (bus3.memresp_val !== 1'b0) begin failures++; $display("FAIL reset_val3: got %b expected 0", bus3.memresp_val); end
    $display("reset: rdy0=%b val0=%b rdy3=%b val3=%b", bus0.memreq_rdy, bus0.memresp_val, bus3.memreq_rdy, bus3.memresp_val);
  endtask

  task automatic test_write_read();
    mem_resp_4B_t r; int lat;
    xact0(3'd1, 32'h100, 32'hDEADBEEF, 8'h01, 2'd0, r, lat);
    $display("write 0x100 <= deadbeef: resp=%h lat=%0d", r, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr_latency: got %0d expected 1", lat); end
    checks++; if (r !== mem_resp_4B_t'{msg_type: 3'd1, opaque: 8'h01, test: 2'd0, len: 2'd0, data: 32'h0})
      begin failures++; $display("FAIL wr_resp: got %h expected type1 opq01 data0", r); end
    xact0(3'd0, 32'h100, 32'h0, 8'h05, 2'd0, r, lat);
    $display("read 0x100: resp=%h lat=%0d", r, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rd_latency: got %0d expected 1", lat); end
    checks++; if (r.data !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", r.data); end
    checks++; if (r.opaque !== 8'h05 || r.msg_type !== 3'd0 || r.test !== 2'd0)
      begin failures++; $display("FAIL rd_header: got opq %h type %0d test %0d expected 05 0 0", r.opaque, r.msg_type, r.test); end
  endtask

  task automatic test_wrap();
    mem_resp_4B_t r; int lat;
    xact0(3'd1, 32'h0, 32'h11, 8'h02, 2'd0, r, lat);
    xact0(3'd0, 32'h400, 32'h0, 8'h03, 2'd0, r, lat);
    $display("wrap read 0x400: data=%h lat=%0d", r.data, lat);
    checks++; if (r.data !== 32'h11 || lat !== 1) begin failures++; $display("FAIL wrap: got %h lat %0d expected 00000011 lat 1", r.data, lat); end
  endtask

  task automatic test_other_type();
    mem_resp_4B_t r; int lat;
    xact0(3'd2, 32'h100, 32'hFFFFFFFF, 8'h09, 2'd0, r, lat);
    $display("type2 0x100: resp=%h", r);
    checks++; if (r.data !== 32'hDEADBEEF || r.msg_type !== 3'd2)
      begin failures++; $display("FAIL type2_resp: got data %h type %0d expected deadbeef 2", r.data, r.msg_type); end
    xact0(3'd0, 32'h100, 32'h0, 8'h0A, 2'd0, r, lat);
    $display("read after type2: data=%h", r.data);
    checks++; if (r.data !== 32'hDEADBEEF) begin failures++; $display("FAIL type2_nowrite: got %h expected deadbeef", r.data); end
  endtask

  task automatic test_subword();
    mem_resp_4B_t r; int lat;
    xact0(3'd1, 32'h20, 32'h12345678, 8'h10, 2'd0, r, lat);
    xact0(3'd1, 32'h21, 32'h000000AB, 8'h11, 2'd1, r, lat);
    checks++; if (r.len !== 2'd1) begin failures++; $display("FAIL len_echo: got %0d expected 1", r.len); end
    xact0(3'd0, 32'h20, 32'h0, 8'h12, 2'd0, r, lat);
    $display("subword word read 0x20: data=%h", r.data);
    checks++; if (r.data !== EXP_WORD20) begin failures++; $display("FAIL sub_word: got %h expected %h", r.data, EXP_WORD20); end
    xact0(3'd0, 32'h23, 32'h0, 8'h13, 2'd1, r, lat);
    $display("subword byte read 0x23: data=%h len=%0d", r.data, r.len);
    checks++; if (r.data !== EXP_BYTE23) begin failures++; $display("FAIL sub_byte: got %h expected %h", r.data, EXP_BYTE23); end
  endtask

  task automatic test_back_to_back();
    mem_resp_4B_t r; int lat;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA0000000 + 32'(i);
      xact0(3'd1, 32'h40 + 32'(4*i), vals[i], 8'(i), 2'd0, r, lat);
    end
    @(negedge clk);
    bus0.memresp_rdy = 1'b1;
    bus0.memreq_msg  = '{msg_type: 3'd0, opaque: 8'h20, addr: 32'h40, len: 2'd0, data: 32'h0};
    bus0.memreq_val  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      $display("b2b beat %0d: val=%b data=%h rdy=%b", i, bus0.memresp_val, bus0.memresp_msg.data, bus0.memreq_rdy);
      checks++;
      if (bus0.memresp_val !== 1'b1 || bus0.memresp_msg.data !== vals[i-1] || bus0.memresp_msg.opaque !== 8'(32'h20 + i - 1))
        begin failures++; $display("FAIL b2b_beat%0d: got val %b data %h expected 1 %h", i, bus0.memresp_val, bus0.memresp_msg.data, vals[i-1]); end
      if (i < 4) begin
        bus0.memreq_msg = '{msg_type: 3'd0, opaque: 8'(32'h20 + i), addr: 32'h40 + 32'(4*i), len: 2'd0, data: 32'h0};
      end else begin
        bus0.memreq_val = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (bus0.memresp_val !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", bus0.memresp_val); end
  endtask

  task automatic test_backpressure();
    mem_resp_4B_t exp_r;
    exp_r = '{msg_type: 3'd0, opaque: 8'h07, test: 2'd0, len: 2'd0, data: 32'hDEADBEEF};
    @(negedge clk);
    bus0.memresp_rdy = 1'b0;
    bus0.memreq_msg  = '{msg_type: 3'd0, opaque: 8'h07, addr: 32'h100, len: 2'd0, data: 32'h0};
    bus0.memreq_val  = 1'b1;
    @(posedge clk); #1;
    bus0.memreq_msg  = '{msg_type: 3'd0, opaque: 8'h08, addr: 32'h0, len: 2'd0, data: 32'h0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("stall %0d: val=%b msg=%h rdy=%b", i, bus0.memresp_val, bus0.memresp_msg, bus0.memreq_rdy);
      checks++;
      if (bus0.memresp_val !== 1'b1 || bus0.memresp_msg !== exp_r || bus0.memreq_rdy !== 1'b0)
        begin failures++; $display("FAIL stall%0d: got val %b msg %h rdy %b expected 1 %h 0", i, bus0.memresp_val, bus0.memresp_msg, bus0.memreq_rdy, exp_r); end
    end
    @(negedge clk);
    bus0.memresp_rdy = 1'b1;
    #1;
    checks++; if (bus0.memreq_rdy !== 1'b1) begin failures++; $display("FAIL release_rdy: got %b expected 1", bus0.memreq_rdy); end
    @(negedge clk);
    bus0.memreq_val = 1'b0;
    $display("after release: val=%b data=%h opq=%h", bus0.memresp_val, bus0.memresp_msg.data, bus0.memresp_msg.opaque);
    checks++;
    if (bus0.memresp_val !== 1'b1 || bus0.memresp_msg.data !== 32'h11 || bus0.memresp_msg.opaque !== 8'h08)
      begin failures++; $display("FAIL release_next: got val %b data %h opq %h expected 1 00000011 08", bus0.memresp_val, bus0.memresp_msg.data, bus0.memresp_msg.opaque); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency3();
    mem_resp_4B_t r; int lat;
    xact3(3'd1, 32'h8, 32'hCAFE0001, 8'h30, 2'd0, r, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL lat3_write: got %0d expected 4", lat); end
    @(negedge clk);
    bus3.memresp_rdy = 1'b1;
    bus3.memreq_msg  = '{msg_type: 3'd0, opaque: 8'h31, addr: 32'h8, len: 2'd0, data: 32'h0};
    bus3.memreq_val  = 1'b1;
    checks++; if (bus3.memreq_rdy !== 1'b1) begin failures++; $display("FAIL lat3_accept: got %b expected 1", bus3.memreq_rdy); end
    @(posedge clk); #1;
    bus3.memreq_val = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus3.memreq_rdy !== 1'b0 || bus3.memresp_val !== 1'b0)
        begin failures++; $display("FAIL lat3_wait%0d: got rdy %b val %b expected 0 0", k, bus3.memreq_rdy, bus3.memresp_val); end
    end
    @(negedge clk);
    $display("lat3 t+4: val=%b data=%h", bus3.memresp_val, bus3.memresp_msg.data);
    checks++;
    if (bus3.memresp_val !== 1'b1 || bus3.memresp_msg.data !== 32'hCAFE0001)
      begin failures++; $display("FAIL lat3_resp: got val %b data %h expected 1 cafe0001", bus3.memresp_val, bus3.memresp_msg.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    mem_resp_4B_t r; int lat; int seen;
    @(negedge clk);
    bus3.memresp_rdy = 1'b1;
    bus3.memreq_msg  = '{msg_type: 3'd0, opaque: 8'h40, addr: 32'h8, len: 2'd0, data: 32'h0};
    bus3.memreq_val  = 1'b1;
    @(posedge clk); #1;
    bus3.memreq_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus3.memresp_val !== 1'b0 || bus3.memreq_rdy !== 1'b1 || bus3.memresp_msg !== '0)
      begin failures++; $display("FAIL midrst_state: got val %b rdy %b msg %h expected 0 1 0", bus3.memresp_val, bus3.memreq_rdy, bus3.memresp_msg); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus3.memresp_val) seen++;
    end
    $display("after mid reset: stray responses=%0d", seen);
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_dropped: got %0d responses expected 0", seen); end
    xact3(3'd0, 32'h8, 32'h0, 8'h41, 2'd0, r, lat);
    $display("post-reset read 0x8: data=%h lat=%0d", r.data, lat);
    checks++;
    if (r.data !== 32'hCAFE0001 || lat !== 4 || r.opaque !== 8'h41)
      begin failures++; $display("FAIL midrst_next: got data %h lat %0d opq %h expected cafe0001 4 41", r.data, lat, r.opaque); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_other_type();
    test_subword();
    test_back_to_back();
    test_backpressure();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
